// File: rtl/fpu_fp16_to_int.sv
// fpu_fp16_to_int: sequential FP16 to signed 16-bit integer converter.
// Rounds toward zero and saturates out-of-range operands.
// Condition codes are reported as {Z, C, N, V}.
// The integer part is normalised by an iterative left shift of one bit per
// cycle. Valid/ready handshakes on both sides let the block sit between the
// FPU result bus and the integer writeback path.

module fpu_fp16_to_int (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] fpuIn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] intOut,
    output logic [3:0]  condCodes
);

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } condCode_t;

    typedef struct packed {
        logic [15:0] value;
        condCode_t   cc;
    } result_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [15:0] INT_MAX = 16'h7FFF;
    localparam logic [15:0] INT_MIN = 16'h8000;

    state_t      state;
    logic        sign;
    logic [25:0] acc;
    logic [3:0]  count;

    fp16_t       operand;
    logic        accept;
    logic [25:0] loadAcc;
    logic [3:0]  loadCount;
    logic [25:0] accShifted;
    logic        isSpecial;
    result_t     special;
    result_t     acceptResult;
    result_t     shiftResult;

    // Truncating conversion of a fixed-point magnitude with 10 fraction bits.
    function automatic result_t normalResult(input logic s, input logic [25:0] a);
        result_t     r;
        logic [15:0] mag;
        mag        = a[25:10];
        r.value    = s ? (~mag + 16'd1) : mag;
        r.cc.z     = (r.value == 16'd0);
        r.cc.c     = |a[9:0];
        r.cc.n     = r.value[15];
        r.cc.v     = 1'b0;
        return r;
    endfunction

    assign operand    = fpuIn;
    assign in_ready   = (state == IDLE) & reset_L;
    assign accept     = in_valid & in_ready;
    assign loadAcc    = {15'b0, 1'b1, operand.frac};
    // Only evaluated for exp in 15..29, so exp-15 fits in four bits and the
    // low exponent bits give the same result modulo 16.
    assign loadCount  = operand.exp[3:0] - 4'd15;
    assign accShifted = acc << 1;

    assign acceptResult = normalResult(operand.sign, loadAcc);
    assign shiftResult  = normalResult(sign, accShifted);

    // Classify the incoming operand and build the result for every case that
    // needs no normalisation shifts (NaN, Inf, saturation, |x| < 1).
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        special   = '0;
        isSpecial = 1'b1;
        if (operand.exp == 5'd31) begin
            special.cc.v = 1'b1;
            if (operand.frac != 10'd0) begin
                special.cc.z = 1'b1;
            end else begin
                special.value = operand.sign ? INT_MIN : INT_MAX;
                special.cc.n  = operand.sign;
            end
        end else if (operand.exp == 5'd30) begin
            // Only -32768 itself is representable; everything else saturates.
            special.value = operand.sign ? INT_MIN : INT_MAX;
            special.cc.n  = operand.sign;
            special.cc.v  = !(operand.sign && (operand.frac == 10'd0));
        end else if (operand.exp < 5'd15) begin
            special.cc.z = 1'b1;
            special.cc.c = (operand.exp != 5'd0) || (operand.frac != 10'd0);
        end else begin
            isSpecial = 1'b0;
        end
    end

    // Control FSM plus datapath: accept, shift-normalise, hold result until taken.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            sign      <= 1'b0;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            intOut    <= '0;
            condCodes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign  <= operand.sign;
                        acc   <= loadAcc;
                        count <= loadCount;
                        if (isSpecial) begin
                            intOut    <= special.value;
                            condCodes <= special.cc;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (loadCount == 4'd0) begin
                            intOut    <= acceptResult.value;
                            condCodes <= acceptResult.cc;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc   <= accShifted;
                    count <= count - 4'd1;
                    // The shift that brings count to zero also registers the result.
                    if (count == 4'd1) begin
                        intOut    <= shiftResult.value;
                        condCodes <= shiftResult.cc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
